// File: rtl/mips_pkg.sv
// Shared MIPS control definitions.
// Holds the multicycle state encoding, opcode and funct constants, the
// datapath ALU control codes and the alu_src_b / pc_src mux encodings.
// The single-cycle control path imports the same opcode and ALU constants.
package mips_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BREX    = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_NOR = 6'b100111;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_NOR = 3'b100;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // States that wait on the memory ready handshake.
    function automatic logic is_mem_wait_state(state_t s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Control bundle between the multicycle controller and its datapath.
// Inputs to the controller: op, funct, zero, mem_ready.
// Outputs from the controller: memory strobes, register/PC enables, mux
// selects, alu_control, illegal_op / mem_timeout pulses and state_o.
// master = controller side, slave = datapath side.
interface mips_multicycle_ctrl_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;

    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       pc_en;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_control;
    logic [1:0] pc_src;
    logic       illegal_op;
    logic       mem_timeout;
    logic [3:0] state_o;

    modport master (
        input  op, funct, zero, mem_ready,
        output iord, mem_read, mem_write, ir_write, pc_en, reg_dst,
               mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_control,
               pc_src, illegal_op, mem_timeout, state_o
    );

    modport slave (
        output op, funct, zero, mem_ready,
        input  iord, mem_read, mem_write, ir_write, pc_en, reg_dst,
               mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_control,
               pc_src, illegal_op, mem_timeout, state_o
    );
endinterface

// File: rtl/mips_alu_decoder.sv
// R-type ALU decoder, shared with the single-cycle control path.
// Ports: funct (IR[5:0]) in; alu_control (datapath ALU code) and
// funct_valid (funct is one of the supported R-type operations) out.
module mips_alu_decoder
    import mips_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] alu_control,
    output logic       funct_valid
);

    always_comb begin
        alu_control = ALU_ADD;
        funct_valid = 1'b1;
        case (funct)
            FN_ADD:  alu_control = ALU_ADD;
            FN_SUB:  alu_control = ALU_SUB;
            FN_AND:  alu_control = ALU_AND;
            FN_OR:   alu_control = ALU_OR;
            FN_SLT:  alu_control = ALU_SLT;
            FN_NOR:  alu_control = ALU_NOR;
            default: funct_valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS controller: one FSM sequencing fetch, decode, execute,
// memory and writeback, with the ALU decoder folded in and a ready/timeout
// handshake on memory accesses.
// Ports: clk (rising edge), rst_n (async, active-low), bus (master side of
// mips_multicycle_ctrl_if carrying op/funct/zero/mem_ready in and all
// datapath controls out).
//
// state    | meaning
// ---------+-----------------------------------------------
// FETCH    | read instr at PC, load IR, PC <= PC+4 on ready
// DECODE   | ALUOut <= PC + (imm<<2), pick execute path
// MEMADR   | ALUOut <= A + imm (lw/sw address)
// MEMRD    | read data memory at ALUOut
// MEMWB    | rt <= MDR
// MEMWR    | write B to data memory at ALUOut
// RTYPEEX  | ALUOut <= A op B
// RTYPEWB  | rd <= ALUOut
// BREX     | compare A-B, load branch target on taken
// ADDIEX   | ALUOut <= A + imm
// ADDIWB   | rt <= ALUOut
// JEX      | PC <= jump target
module mips_multicycle_ctrl
    import mips_pkg::*;
#(
    parameter int MEM_WAIT_EN = 1,
    parameter int BNE_EN      = 1,
    parameter int MAX_WAIT    = 0,
    parameter int WAIT_CNT_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    mips_multicycle_ctrl_if.master  bus
);

    state_t                state, state_nx, dec_nx;
    logic [WAIT_CNT_W-1:0] wait_cnt;
    logic                  rdy, in_wait, timeout, dec_legal;
    logic                  funct_valid;
    logic [2:0]            funct_alu;

    logic       iord_c, mem_read_c, mem_write_c, ir_write_c, pc_en_c;
    logic       reg_dst_c, mem_to_reg_c, reg_write_c, alu_src_a_c;
    logic [1:0] alu_src_b_c, pc_src_c;
    logic [2:0] alu_control_c;

    mips_alu_decoder u_alu_dec (
        .funct       (bus.funct),
        .alu_control (funct_alu),
        .funct_valid (funct_valid)
    );

    assign rdy     = bus.mem_ready || (MEM_WAIT_EN == 0);
    assign in_wait = is_mem_wait_state(state);
    // Ready on the same cycle as count==MAX_WAIT wins over the abort.
    assign timeout = (MAX_WAIT > 0) && in_wait && !rdy &&
                     (wait_cnt == WAIT_CNT_W'(MAX_WAIT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_FETCH;
        else        state <= state_nx;
    end

    // A timeout in FETCH stays in FETCH, so it must clear the count itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if ((state_nx != state) || timeout) begin
            wait_cnt <= '0;
        end else if (in_wait && !rdy && (wait_cnt != '1)) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    always_comb begin
        dec_nx    = S_FETCH;
        dec_legal = 1'b1;
        case (bus.op)
            OP_RTYPE: begin
                if (funct_valid) dec_nx = S_RTYPEEX;
                else             dec_legal = 1'b0;
            end
            OP_LW, OP_SW: dec_nx = S_MEMADR;
            OP_BEQ:       dec_nx = S_BREX;
            OP_BNE: begin
                if (BNE_EN != 0) dec_nx = S_BREX;
                else             dec_legal = 1'b0;
            end
            OP_ADDI: dec_nx = S_ADDIEX;
            OP_J:    dec_nx = S_JEX;
            default: dec_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_nx = S_FETCH;
        case (state)
            S_FETCH:   state_nx = rdy ? S_DECODE : S_FETCH;
            S_DECODE:  state_nx = dec_nx;
            S_MEMADR: begin
                if (bus.op == OP_LW)      state_nx = S_MEMRD;
                else if (bus.op == OP_SW) state_nx = S_MEMWR;
                else                      state_nx = S_FETCH;
            end
            S_MEMRD: begin
                if (rdy)          state_nx = S_MEMWB;
                else if (timeout) state_nx = S_FETCH;
                else              state_nx = S_MEMRD;
            end
            S_MEMWB:   state_nx = S_FETCH;
            S_MEMWR:   state_nx = (rdy || timeout) ? S_FETCH : S_MEMWR;
            S_RTYPEEX: state_nx = S_RTYPEWB;
            S_RTYPEWB: state_nx = S_FETCH;
            S_BREX:    state_nx = S_FETCH;
            S_ADDIEX:  state_nx = S_ADDIWB;
            S_ADDIWB:  state_nx = S_FETCH;
            S_JEX:     state_nx = S_FETCH;
            default:   state_nx = S_FETCH;
        endcase
    end

    always_comb begin
        iord_c        = 1'b0;
        mem_read_c    = 1'b0;
        mem_write_c   = 1'b0;
        ir_write_c    = 1'b0;
        pc_en_c       = 1'b0;
        reg_dst_c     = 1'b0;
        mem_to_reg_c  = 1'b0;
        reg_write_c   = 1'b0;
        alu_src_a_c   = 1'b0;
        alu_src_b_c   = SRCB_B;
        alu_control_c = ALU_AND;
        pc_src_c      = PCSRC_ALU;
        case (state)
            S_FETCH: begin
                mem_read_c    = 1'b1;
                alu_src_b_c   = SRCB_FOUR;
                alu_control_c = ALU_ADD;
                ir_write_c    = rdy;
                pc_en_c       = rdy;
            end
            S_DECODE: begin
                alu_src_b_c   = SRCB_IMM_SH2;
                alu_control_c = ALU_ADD;
            end
            S_MEMADR, S_ADDIEX: begin
                alu_src_a_c   = 1'b1;
                alu_src_b_c   = SRCB_IMM;
                alu_control_c = ALU_ADD;
            end
            S_MEMRD: begin
                mem_read_c = 1'b1;
                iord_c     = 1'b1;
            end
            S_MEMWB: begin
                mem_to_reg_c = 1'b1;
                reg_write_c  = 1'b1;
            end
            S_MEMWR: begin
                mem_write_c = 1'b1;
                iord_c      = 1'b1;
            end
            S_RTYPEEX: begin
                alu_src_a_c   = 1'b1;
                alu_control_c = funct_alu;
            end
            S_RTYPEWB: begin
                reg_dst_c   = 1'b1;
                reg_write_c = 1'b1;
            end
            S_BREX: begin
                alu_src_a_c   = 1'b1;
                alu_control_c = ALU_SUB;
                pc_src_c      = PCSRC_ALUOUT;
                pc_en_c       = (bus.op == OP_BNE) ? !bus.zero : bus.zero;
            end
            S_ADDIWB: reg_write_c = 1'b1;
            S_JEX: begin
                pc_src_c = PCSRC_JUMP;
                pc_en_c  = 1'b1;
            end
            default: ;
        endcase
    end

    // Strobes are gated by rst_n so nothing fires while reset is held,
    // even though FETCH itself would request a read.
    assign bus.mem_read    = mem_read_c  & rst_n;
    assign bus.mem_write   = mem_write_c & rst_n;
    assign bus.ir_write    = ir_write_c  & rst_n;
    assign bus.pc_en       = pc_en_c     & rst_n;
    assign bus.reg_write   = reg_write_c & rst_n;
    assign bus.illegal_op  = (state == S_DECODE) && !dec_legal && rst_n;
    assign bus.mem_timeout = timeout && rst_n;

    assign bus.iord        = iord_c;
    assign bus.reg_dst     = reg_dst_c;
    assign bus.mem_to_reg  = mem_to_reg_c;
    assign bus.alu_src_a   = alu_src_a_c;
    assign bus.alu_src_b   = alu_src_b_c;
    assign bus.alu_control = alu_control_c;
    assign bus.pc_src      = pc_src_c;
    assign bus.state_o     = state;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
module tb_mips_multicycle_ctrl;
    import mips_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n, rst_n_nb;
    logic [5:0] op, funct;
    logic       zero, mem_ready;
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    mips_multicycle_ctrl_if bus ();
    mips_multicycle_ctrl_if nb_bus ();

    assign bus.op = op;
    assign bus.funct = funct;
    assign bus.zero = zero;
    assign bus.mem_ready = mem_ready;
    assign nb_bus.op = op;
    assign nb_bus.funct = funct;
    assign nb_bus.zero = zero;
    assign nb_bus.mem_ready = mem_ready;

    mips_multicycle_ctrl #(.MEM_WAIT_EN(1), .BNE_EN(1), .MAX_WAIT(3), .WAIT_CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    mips_multicycle_ctrl #(.MEM_WAIT_EN(1), .BNE_EN(0), .MAX_WAIT(0), .WAIT_CNT_W(8)) dut_nb (
        .clk   (clk),
        .rst_n (rst_n_nb),
        .bus   (nb_bus)
    );

    typedef struct packed {
        logic [3:0] state;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       pc_en;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       src_a;
        logic [1:0] src_b;
        logic [2:0] alu;
        logic [1:0] pc_src;
        logic       illegal;
        logic       timeout;
    } ctrl_t;

    ctrl_t obs_main, obs_nb;
    assign obs_main = {bus.state_o, bus.iord, bus.mem_read, bus.mem_write, bus.ir_write,
                       bus.pc_en, bus.reg_dst, bus.mem_to_reg, bus.reg_write, bus.alu_src_a,
                       bus.alu_src_b, bus.alu_control, bus.pc_src, bus.illegal_op,
                       bus.mem_timeout};
    assign obs_nb = {nb_bus.state_o, nb_bus.iord, nb_bus.mem_read, nb_bus.mem_write,
                     nb_bus.ir_write, nb_bus.pc_en, nb_bus.reg_dst, nb_bus.mem_to_reg,
                     nb_bus.reg_write, nb_bus.alu_src_a, nb_bus.alu_src_b,
                     nb_bus.alu_control, nb_bus.pc_src, nb_bus.illegal_op,
                     nb_bus.mem_timeout};

    // Field order: state iord mrd mwr irw pcen rdst m2r rw srca srcb alu pcsrc ill to
    localparam ctrl_t E_RESET    = '{4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 3'b010, 2'b00, 1'b0, 1'b0};
    localparam ctrl_t E_FETCH_R  = '{4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 3'b010, 2'b00, 1'b0, 1'b0};
    localparam ctrl_t E_FETCH_W  = '{4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 3'b010, 2'b00, 1'b0, 1'b0};
    localparam ctrl_t E_FETCH_TO = '{4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 3'b010, 2'b00, 1'b0, 1'b1};
    localparam ctrl_t E_DEC      = '{4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 3'b010, 2'b00, 1'b0, 1'b0};
    localparam ctrl_t E_DEC_ILL  = '{4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 3'b010, 2'b00, 1'b1, 1'b0};
    localparam ctrl_t E_MEMADR   = '{4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 3'b010, 2'b00, 1'b0, 1'b0};
    localparam ctrl_t E_MEMRD    = '{4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 2'b00, 1'b0, 1'b0};
    localparam ctrl_t E_MEMWB    = '{4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 3'b000, 2'b00, 1'b0, 1'b0};
    localparam ctrl_t E_MEMWR    = '{4'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 2'b00, 1'b0, 1'b0};
    localparam ctrl_t E_RT_SUB   = '{4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 3'b110, 2'b00, 1'b0, 1'b0};
    localparam ctrl_t E_RT_SLT   = '{4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 3'b111, 2'b00, 1'b0, 1'b0};
    localparam ctrl_t E_RT_WB    = '{4'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 3'b000, 2'b00, 1'b0, 1'b0};
    localparam ctrl_t E_BR_T     = '{4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 3'b110, 2'b01, 1'b0, 1'b0};
    localparam ctrl_t E_BR_N     = '{4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 3'b110, 2'b01, 1'b0, 1'b0};
    localparam ctrl_t E_ADDIEX   = '{4'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 3'b010, 2'b00, 1'b0, 1'b0};
    localparam ctrl_t E_ADDIWB   = '{4'd10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 3'b000, 2'b00, 1'b0, 1'b0};
    localparam ctrl_t E_JEX      = '{4'd11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 2'b10, 1'b0, 1'b0};

    typedef struct {
        string      name;
        logic [5:0] op;
        logic [5:0] funct;
        logic       zero;
        logic       rdy;
        ctrl_t      exp;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(string n, logic [5:0] o, logic [5:0] f, logic z, logic r, ctrl_t e);
        vec_t v;
        v.name = n;
        v.op = o;
        v.funct = f;
        v.zero = z;
        v.rdy = r;
        v.exp = e;
        vecs.push_back(v);
    endfunction

    task automatic check(string n, ctrl_t got, ctrl_t exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", n, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        rst_n_nb = 1'b0;
        op = OP_LW;
        funct = 6'b0;
        zero = 1'b0;
        mem_ready = 1'b1;

        // Each entry: inputs for one cycle and the controls expected in it.
        add("lw_fetch", OP_LW, 6'd0, 1'b0, 1'b1, E_FETCH_R);
        add("lw_dec",   OP_LW, 6'd0, 1'b0, 1'b1, E_DEC);
        add("lw_adr",   OP_LW, 6'd0, 1'b0, 1'b1, E_MEMADR);
        add("lw_rd",    OP_LW, 6'd0, 1'b0, 1'b1, E_MEMRD);
        add("lw_wb",    OP_LW, 6'd0, 1'b0, 1'b1, E_MEMWB);
        add("sw_fetch", OP_SW, 6'd0, 1'b0, 1'b1, E_FETCH_R);
        add("sw_dec",   OP_SW, 6'd0, 1'b0, 1'b1, E_DEC);
        add("sw_adr",   OP_SW, 6'd0, 1'b0, 1'b1, E_MEMADR);
        add("sw_wr",    OP_SW, 6'd0, 1'b0, 1'b1, E_MEMWR);
        add("sub_fetch", OP_RTYPE, FN_SUB, 1'b0, 1'b1, E_FETCH_R);
        add("sub_dec",   OP_RTYPE, FN_SUB, 1'b0, 1'b1, E_DEC);
        add("sub_ex",    OP_RTYPE, FN_SUB, 1'b0, 1'b1, E_RT_SUB);
        add("sub_wb",    OP_RTYPE, FN_SUB, 1'b0, 1'b1, E_RT_WB);
        add("slt_fetch", OP_RTYPE, FN_SLT, 1'b0, 1'b1, E_FETCH_R);
        add("slt_dec",   OP_RTYPE, FN_SLT, 1'b0, 1'b1, E_DEC);
        add("slt_ex",    OP_RTYPE, FN_SLT, 1'b0, 1'b1, E_RT_SLT);
        add("slt_wb",    OP_RTYPE, FN_SLT, 1'b0, 1'b1, E_RT_WB);
        add("beq1_fetch", OP_BEQ, 6'd0, 1'b1, 1'b1, E_FETCH_R);
        add("beq1_dec",   OP_BEQ, 6'd0, 1'b1, 1'b1, E_DEC);
        add("beq1_ex",    OP_BEQ, 6'd0, 1'b1, 1'b1, E_BR_T);
        add("beq0_fetch", OP_BEQ, 6'd0, 1'b0, 1'b1, E_FETCH_R);
        add("beq0_dec",   OP_BEQ, 6'd0, 1'b0, 1'b1, E_DEC);
        add("beq0_ex",    OP_BEQ, 6'd0, 1'b0, 1'b1, E_BR_N);
        add("bne0_fetch", OP_BNE, 6'd0, 1'b0, 1'b1, E_FETCH_R);
        add("bne0_dec",   OP_BNE, 6'd0, 1'b0, 1'b1, E_DEC);
        add("bne0_ex",    OP_BNE, 6'd0, 1'b0, 1'b1, E_BR_T);
        add("bne1_fetch", OP_BNE, 6'd0, 1'b1, 1'b1, E_FETCH_R);
        add("bne1_dec",   OP_BNE, 6'd0, 1'b1, 1'b1, E_DEC);
        add("bne1_ex",    OP_BNE, 6'd0, 1'b1, 1'b1, E_BR_N);
        add("addi_fetch", OP_ADDI, 6'd0, 1'b0, 1'b1, E_FETCH_R);
        add("addi_dec",   OP_ADDI, 6'd0, 1'b0, 1'b1, E_DEC);
        add("addi_ex",    OP_ADDI, 6'd0, 1'b0, 1'b1, E_ADDIEX);
        add("addi_wb",    OP_ADDI, 6'd0, 1'b0, 1'b1, E_ADDIWB);
        add("j_fetch", OP_J, 6'd0, 1'b0, 1'b1, E_FETCH_R);
        add("j_dec",   OP_J, 6'd0, 1'b0, 1'b1, E_DEC);
        add("j_ex",    OP_J, 6'd0, 1'b0, 1'b1, E_JEX);
        add("illfn_fetch", OP_RTYPE, 6'b000000, 1'b0, 1'b1, E_FETCH_R);
        add("illfn_dec",   OP_RTYPE, 6'b000000, 1'b0, 1'b1, E_DEC_ILL);
        add("illop_fetch", 6'b111111, 6'd0, 1'b0, 1'b1, E_FETCH_R);
        add("illop_dec",   6'b111111, 6'd0, 1'b0, 1'b1, E_DEC_ILL);
        add("lwwait_fetch", OP_LW, 6'd0, 1'b0, 1'b1, E_FETCH_R);
        add("lwwait_dec",   OP_LW, 6'd0, 1'b0, 1'b1, E_DEC);
        add("lwwait_adr",   OP_LW, 6'd0, 1'b0, 1'b1, E_MEMADR);
        add("lwwait_rd0",   OP_LW, 6'd0, 1'b0, 1'b0, E_MEMRD);
        add("lwwait_rd1",   OP_LW, 6'd0, 1'b0, 1'b0, E_MEMRD);
        add("lwwait_rd2",   OP_LW, 6'd0, 1'b0, 1'b1, E_MEMRD);
        add("lwwait_wb",    OP_LW, 6'd0, 1'b0, 1'b1, E_MEMWB);
        add("to_w0",    OP_J, 6'd0, 1'b0, 1'b0, E_FETCH_W);
        add("to_w1",    OP_J, 6'd0, 1'b0, 1'b0, E_FETCH_W);
        add("to_w2",    OP_J, 6'd0, 1'b0, 1'b0, E_FETCH_W);
        add("to_abort", OP_J, 6'd0, 1'b0, 1'b0, E_FETCH_TO);
        add("to_re0",   OP_J, 6'd0, 1'b0, 1'b0, E_FETCH_W);
        add("to_re1",   OP_J, 6'd0, 1'b0, 1'b0, E_FETCH_W);
        add("to_re2",   OP_J, 6'd0, 1'b0, 1'b0, E_FETCH_W);
        add("rdy_at_max", OP_J, 6'd0, 1'b0, 1'b1, E_FETCH_R);
        add("rdy_dec",    OP_J, 6'd0, 1'b0, 1'b1, E_DEC);
        add("rdy_jex",    OP_J, 6'd0, 1'b0, 1'b1, E_JEX);

        step();
        step();
        check("reset_state", obs_main, E_RESET);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            op = vecs[i].op;
            funct = vecs[i].funct;
            zero = vecs[i].zero;
            mem_ready = vecs[i].rdy;
            #1;
            check(vecs[i].name, obs_main, vecs[i].exp);
            step();
        end

        // Asynchronous reset in the middle of a stalled store.
        op = OP_SW;
        mem_ready = 1'b1;
        #1;
        check("rst_sw_fetch", obs_main, E_FETCH_R);
        step();
        check("rst_sw_dec", obs_main, E_DEC);
        step();
        check("rst_sw_adr", obs_main, E_MEMADR);
        step();
        mem_ready = 1'b0;
        #1;
        check("rst_sw_wr", obs_main, E_MEMWR);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async", obs_main, E_RESET);
        step();
        check("rst_held", obs_main, E_RESET);
        rst_n = 1'b1;
        mem_ready = 1'b1;
        #1;
        check("rst_refetch", obs_main, E_FETCH_R);
        step();
        check("rst_redec", obs_main, E_DEC);

        // BNE disabled: 000101 is illegal; no timeout when MAX_WAIT is 0.
        step();
        rst_n_nb = 1'b1;
        op = OP_BNE;
        zero = 1'b0;
        mem_ready = 1'b1;
        #1;
        check("nb_fetch", obs_nb, E_FETCH_R);
        step();
        check("nb_dec_ill", obs_nb, E_DEC_ILL);
        step();
        mem_ready = 1'b0;
        #1;
        check("nb_back_fetch", obs_nb, E_FETCH_W);
        for (int k = 0; k < 6; k++) begin
            step();
            check("nb_no_timeout", obs_nb, E_FETCH_W);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
